// File: rtl/fetch_stage_pkg.sv
// Shared WISC-F24 fetch definitions: opcode constants, fetch FSM encodings,
// IF/ID payload type and the PC increment helper.
package fetch_stage_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned STATE_W = 2;

    // Opcode constants also consumed by decode and the ALU-op decoder
    localparam logic [OPC_W-1:0] OPC_HALT  = 5'b00000;
    localparam logic [XLEN-1:0]  INSTR_NOP = 16'h0800;

    // Fetch FSM state encodings
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 2'b00,
        ST_HOLD   = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_t;

    // One fetched word together with its link / branch-base value
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus2;
    } fetch_word_t;

    // 16-bit modulo increment; 0xFFFE wraps to 0x0000 silently
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return XLEN'(pc + XLEN'(2));
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_latch.sv
// IF/ID pipeline register with stall (hold) and flush (bubble) control.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          insert bubble regardless of stall (redirect)
//   stall          hold all fields
//   load, word     deliver a real instruction when not stalled
//   instr          instruction to decode
//   pc_plus2       PC+2 of that instruction
//   valid          1 = real instruction, 0 = bubble
module fetch_stage_if_id_latch
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             load,
    input  fetch_word_t      word,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  pc_plus2,
    output logic             valid
);

    // Flush beats stall; without a word, an unstalled latch fills with a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= word.instr;
                pc_plus2 <= word.pc_plus2;
                valid    <= 1'b1;
            end else begin
                instr    <= NOP_INSTR;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage for the WISC-F24 pipeline: PC, skid buffer and
// fetch FSM driving a variable-latency instruction memory, feeding IF/ID.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_addr/rd      read address and request (held while a read is outstanding)
//   imem_data/done    read data and completion strobe
//   redirect_en/pc    taken branch/jump from execute
//   id_stall          hazard unit hold of IF/ID
//   if_id_*           instruction, PC+2 and valid delivered to decode
//   halted            HALT captured, fetching stopped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0]  RESET_PC  = 16'h0000,
    parameter logic [XLEN-1:0]  NOP_INSTR = INSTR_NOP,
    parameter logic [OPC_W-1:0] HALT_OPC  = OPC_HALT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  imem_addr,
    output logic             imem_rd,
    input  logic [XLEN-1:0]  imem_data,
    input  logic             imem_done,
    input  logic             redirect_en,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             id_stall,
    output logic [XLEN-1:0]  if_id_instr,
    output logic [XLEN-1:0]  if_id_pc_plus2,
    output logic             if_id_valid,
    output logic             halted
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] addr_next;
    fetch_word_t     skid, skid_next;
    logic            halted_next;

    logic            capture;
    logic            load;
    fetch_word_t     cap_word;
    fetch_word_t     load_word;

    assign cap_word.instr    = imem_data;
    assign cap_word.pc_plus2 = pc_inc(pc);

    // Request derives from registered state; reset must mask it immediately
    assign imem_rd = !rst && ((state == ST_FETCH) || (state == ST_DRAIN));

    // Next-state, PC, address and skid computation
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        skid_next   = skid;
        capture     = 1'b0;
        load        = 1'b0;
        load_word   = cap_word;

        if (redirect_en) begin
            pc_next   = redirect_pc;
            skid_next = '0;
            unique case (state)
                ST_FETCH:  state_next = imem_done ? ST_FETCH : ST_DRAIN;
                ST_DRAIN:  state_next = ST_DRAIN;
                default:   state_next = ST_FETCH;
            endcase
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (imem_done) begin
                        capture = 1'b1;
                        pc_next = pc_inc(pc);
                        if (id_stall) begin
                            skid_next  = cap_word;
                            state_next = ST_HOLD;
                        end else begin
                            load       = 1'b1;
                            state_next = (imem_data[15:11] == HALT_OPC) ? ST_HALTED : ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!id_stall) begin
                        load       = 1'b1;
                        load_word  = skid;
                        state_next = (skid.instr[15:11] == HALT_OPC) ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_done) begin
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    state_next = ST_HALTED;
                end
            endcase
        end

        // A read still in flight keeps its address until it completes
        addr_next   = (state_next == ST_DRAIN) ? imem_addr : pc_next;
        halted_next = (state_next == ST_HALTED);
    end

    // State, PC, address, skid and halt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            skid      <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
            skid      <= skid_next;
            halted    <= halted_next;
        end
    end

    fetch_stage_if_id_latch #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_en),
        .stall    (id_stall),
        .load     (load),
        .word     (load_word),
        .instr    (if_id_instr),
        .pc_plus2 (if_id_pc_plus2),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        id_stall;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    int tests_run;
    int tests_failed;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_data      (imem_data),
        .imem_done      (imem_done),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic done, input logic [15:0] data, input logic stall,
                         input logic redir, input logic [15:0] rpc);
        imem_done   = done;
        imem_data   = data;
        id_stall    = stall;
        redirect_en = redir;
        redirect_pc = rpc;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] instr,
                              input logic [15:0] pc2, input logic vld);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc2"},   if_id_pc_plus2, pc2);
        check({tag, ".valid"}, 16'(if_id_valid), 16'(vld));
    endtask

    task automatic check_rd(input string tag, input logic rd, input logic [15:0] addr);
        check({tag, ".rd"},   16'(imem_rd), 16'(rd));
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        tick();

        // Reset values
        check_rd("rst", 1'b0, 16'h0000);
        check_ifid("rst", 16'h0800, 16'h0000, 1'b0);
        check("rst.halted", 16'(halted), 16'h0);

        // 1: back-to-back single-cycle reads
        rst = 1'b0;
        #1;
        check_rd("t1.c0", 1'b1, 16'h0000);
        drive(1'b1, 16'h4001, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t1.w0", 16'h4001, 16'h0002, 1'b1);
        check_rd("t1.c1", 1'b1, 16'h0002);
        drive(1'b1, 16'h4002, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t1.w1", 16'h4002, 16'h0004, 1'b1);
        check_rd("t1.c2", 1'b1, 16'h0004);

        // 2: three-cycle memory latency
        drive(1'b0, 16'hdead, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_rd("t2.wait", 1'b1, 16'h0004);
            check_ifid("t2.bubble", 16'h0800, 16'h0004, 1'b0);
        end
        drive(1'b1, 16'h4003, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t2.land", 16'h4003, 16'h0006, 1'b1);
        check_rd("t2.next", 1'b1, 16'h0006);

        // 3: decode stall while a word arrives -> skid
        drive(1'b1, 16'h4004, 1'b1, 1'b0, 16'h0);
        tick();
        check_rd("t3.hold", 1'b0, 16'h0008);
        check_ifid("t3.hold", 16'h4003, 16'h0006, 1'b1);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        tick();
        check_ifid("t3.hold2", 16'h4003, 16'h0006, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t3.rel", 16'h4004, 16'h0008, 1'b1);
        check_rd("t3.rel", 1'b1, 16'h0008);

        // 4: redirect during outstanding read -> drain, late data dropped
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0100);
        tick();
        check_rd("t4.drain", 1'b1, 16'h0008);
        check_ifid("t4.drain", 16'h0800, 16'h0008, 1'b0);
        drive(1'b1, 16'h4005, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t4.drop", 16'h0800, 16'h0008, 1'b0);
        check_rd("t4.new", 1'b1, 16'h0100);

        // 5: HALT, then redirect out of HALTED
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t5.halt", 16'h0000, 16'h0102, 1'b1);
        check("t5.halted", 16'(halted), 16'h1);
        check("t5.rd", 16'(imem_rd), 16'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        check("t5.stay", 16'(halted), 16'h1);
        check_ifid("t5.bubble", 16'h0800, 16'h0102, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0020);
        tick();
        check("t5.unhalt", 16'(halted), 16'h0);
        check_rd("t5.resume", 1'b1, 16'h0020);

        // HALT captured under stall: HOLD first, then HALTED on release
        drive(1'b1, 16'h0123, 1'b1, 1'b0, 16'h0);
        tick();
        check("t5s.nohalt", 16'(halted), 16'h0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t5s.rel", 16'h0123, 16'h0022, 1'b1);
        check("t5s.halted", 16'(halted), 16'h1);

        // 6: PC wrap at 0xFFFE (redirect with done discards the word)
        drive(1'b1, 16'h4444, 1'b0, 1'b1, 16'hfffe);
        tick();
        check_rd("t6.tgt", 1'b1, 16'hfffe);
        check_ifid("t6.flush", 16'h0800, 16'h0022, 1'b0);
        drive(1'b1, 16'h4006, 1'b0, 1'b0, 16'h0);
        tick();
        check_ifid("t6.wrap", 16'h4006, 16'h0000, 1'b1);
        check_rd("t6.wrap", 1'b1, 16'h0000);

        // Reset in the middle of a drain
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200);
        tick();
        check_rd("t6.drain", 1'b1, 16'h0000);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        tick();
        check_rd("t6.rst", 1'b0, 16'h0000);
        check_ifid("t6.rst", 16'h0800, 16'h0000, 1'b0);
        check("t6.rst.halted", 16'(halted), 16'h0);
        rst = 1'b0;
        #1;
        check_rd("t6.post", 1'b1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
